// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter
//   Shares one memory-mapped serial transmit port between two byte producers.
//   Requester A is the CPU-side I/O write path, and requester B is the
//   debug/monitor path. Each requester feeds its own FIFO. A round-robin
//   scheduler drains the FIFOs and issues one-cycle write strobes. It paces
//   the strobes by the port's busy flag, with a timeout in case busy never
//   rises.
//
//   Optional feature: define SERIAL_ARB_DROP_CNT_EN to add the aDrops and
//   bDrops outputs. Each is a saturating count of bytes dropped on a push
//   into a full FIFO.
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   aData/aWe/aFull   requester A byte, push strobe, FIFO full
//   bData/bWe/bFull   requester B byte, push strobe, FIFO full
//   serialOut         registered byte to the serial port
//   serialWe          registered one-cycle write strobe
//   serialBusy        serial port busy flag
//   lastGrant         0 = last byte came from A, 1 = from B
//   idle              state IDLE and both FIFOs empty
//   aDrops/bDrops     (SERIAL_ARB_DROP_CNT_EN only) drop counters

// Per-requester FIFO. Full is judged on the pre-edge count, so a push at
// full is dropped even if a pop happens in the same cycle.
module serial_tx_arbiter_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_data,
  input  logic       i_we,
  input  logic       i_pop,
  output logic [7:0] o_head,
  output logic       o_full,
  output logic       o_empty
`ifdef SERIAL_ARB_DROP_CNT_EN
  ,
  output logic [7:0] o_drops
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_we && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rptr];

  // Storage carries no reset; only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (w_push && rst_n) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifdef SERIAL_ARB_DROP_CNT_EN
  logic [7:0] r_drops;
  assign o_drops = r_drops;

  always_ff @(posedge clk) begin
    if (!rst_n)                                r_drops <= '0;
    else if (i_we && o_full && r_drops != 8'hFF) r_drops <= r_drops + 8'd1;
  end
`endif
endmodule

module serial_tx_arbiter #(
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] aData,
  input  logic       aWe,
  output logic       aFull,
  input  logic [7:0] bData,
  input  logic       bWe,
  output logic       bFull,
  output logic [7:0] serialOut,
  output logic       serialWe,
  input  logic       serialBusy,
  output logic       lastGrant,
  output logic       idle
`ifdef SERIAL_ARB_DROP_CNT_EN
  ,
  output logic [7:0] aDrops,
  output logic [7:0] bDrops
`endif
);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_BUSY, S_WAIT_DONE} state_t;

  state_t        r_state, w_nxt;
  logic [7:0]    r_out;
  logic          r_we, r_last;
  logic [TW-1:0] r_timer;

  // Index 0 = requester A, 1 = requester B.
  logic [1:0][7:0] w_din, w_head;
  logic [1:0]      w_we, w_pop, w_full, w_empty;
  logic            w_grant, w_sel_b;

  assign w_din = {bData, aData};
  assign w_we  = {bWe, aWe};

`ifdef SERIAL_ARB_DROP_CNT_EN
  logic [1:0][7:0] w_drops;
  assign aDrops = w_drops[0];
  assign bDrops = w_drops[1];
`endif

  for (genvar g = 0; g < 2; g++) begin : g_req
    serial_tx_arbiter_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_data  (w_din[g]),
      .i_we    (w_we[g]),
      .i_pop   (w_pop[g]),
      .o_head  (w_head[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
`ifdef SERIAL_ARB_DROP_CNT_EN
      ,
      .o_drops (w_drops[g])
`endif
    );
  end

  assign aFull     = w_full[0];
  assign bFull     = w_full[1];
  assign serialOut = r_out;
  assign serialWe  = r_we;
  assign lastGrant = r_last;
  assign idle      = (r_state == S_IDLE) && (&w_empty);

  always_comb begin
    w_nxt   = r_state;
    w_pop   = '0;
    w_grant = 1'b0;
    // B wins when it alone has data, or when both have data and A went last.
    w_sel_b = !w_empty[1] && (w_empty[0] || !r_last);
    case (r_state)
      S_IDLE: begin
        if (!(&w_empty)) begin
          w_grant = 1'b1;
          w_pop   = w_sel_b ? 2'b10 : 2'b01;
          w_nxt   = S_SEND;
        end
      end
      S_SEND: w_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        // A port that never raises busy is assumed to have taken the byte.
        if (serialBusy)                         w_nxt = S_WAIT_DONE;
        else if (r_timer == TW'(BUSY_TIMEOUT - 1)) w_nxt = S_IDLE;
      end
      S_WAIT_DONE: if (!serialBusy) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_out   <= '0;
      r_we    <= 1'b0;
      r_last  <= 1'b1;
      r_timer <= '0;
    end else begin
      r_state <= w_nxt;
      r_we    <= w_grant;
      if (w_grant) begin
        r_out  <= w_head[w_sel_b];
        r_last <= w_sel_b;
      end
      if (r_state == S_SEND)                        r_timer <= '0;
      else if (r_state == S_WAIT_BUSY && !serialBusy) r_timer <= r_timer + TW'(1);
    end
  end
endmodule
